// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_main_control_if.sv
// Controller <-> datapath signal bundle.
interface mc_main_control_if #(
    parameter int OPC_W = 6
);
    logic [OPC_W-1:0] opcode;
    logic             mem_ready;
    logic             zero;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [1:0]       aluop;
    logic [3:0]       state;
    logic             illegal_op;
    logic             mem_timeout;

    modport master (
        output opcode, mem_ready, zero,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               aluop, state, illegal_op, mem_timeout
    );

    modport slave (
        input  opcode, mem_ready, zero,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
               aluop, state, illegal_op, mem_timeout
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore decode of the control state into datapath enables.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state enables; FETCH gates IR/PC loads on mem_ready so PC advances once per fetch.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = 2'b01;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.aluop     = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.aluop         = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register, sequencing, memory stall watchdog.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPC_W    = 6,
    parameter int WAIT_MAX = 15
) (
    input logic              clk,
    input logic              rst_n,
    mc_main_control_if.slave bus
);

    localparam int             CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0]  WAIT_LIM = CW'(WAIT_MAX);

    state_t           state_q, state_d;
    logic             is_sw_q, is_sw_d;
    logic             illegal;
    logic [CW-1:0]    wait_cnt;
    logic             timeout_q;
    logic             stalled;
    logic [OPC_W-1:0] opc;
    ctrl_t            ctrl;
    logic             unused_zero;

    assign opc         = bus.opcode;
    assign unused_zero = bus.zero;
    assign stalled     = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                         && !bus.mem_ready;

    // State register plus the lw/sw choice captured in DECODE for use in MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // Next-state selection; opcode is only looked at while in DECODE.
    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = 1'b0;
                case (opc)
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW: begin
                        state_d = S_MEMADR;
                        is_sw_d = 1'b1;
                    end
                    OP_RTYPE: state_d = S_EXEC;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Saturating stall counter; timeout latches on the stall that reaches WAIT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (stalled && (wait_cnt != WAIT_LIM)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (stalled && (wait_cnt == WAIT_LIM - 1'b1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.aluop         = ctrl.aluop;
    assign bus.state         = state_q;
    assign bus.illegal_op    = illegal;
    assign bus.mem_timeout   = timeout_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for the multicycle main control.
module tb_mc_main_control;
    import mips_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [16:0] all_out;

    mc_main_control_if #(.OPC_W(6)) bus ();

    mc_main_control #(.OPC_W(6), .WAIT_MAX(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign all_out = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                      bus.aluop, bus.illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = OP_RTYPE;
        bus.zero = 1'b0;
        #2;
        checks++;
        if ({bus.state, all_out, bus.mem_timeout} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp %b", {bus.state, all_out, bus.mem_timeout}, 22'd0);
        end
        step;
        rst_n = 1'b1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle got %0d exp 0", bus.state);
        end
        step;
        checks++;
        if ({bus.state, bus.mem_read, bus.ir_write, bus.pc_write, bus.aluop, bus.alu_src_b} !== {4'd1, 3'b111, 2'b00, 2'b01}) begin
            errors++;
            $display("FAIL fetch_ctrl got %b exp %b",
                     {bus.state, bus.mem_read, bus.ir_write, bus.pc_write, bus.aluop, bus.alu_src_b},
                     {4'd1, 3'b111, 2'b00, 2'b01});
        end
        step;
        checks++;
        if ({bus.state, bus.alu_src_b, bus.aluop} !== {4'd2, 2'b11, 2'b00}) begin
            errors++;
            $display("FAIL decode_ctrl got %b exp %b", {bus.state, bus.alu_src_b, bus.aluop}, {4'd2, 2'b11, 2'b00});
        end
    endtask

    task automatic test_rtype;
        step;
        checks++;
        if ({bus.state, bus.aluop, bus.alu_src_a, bus.alu_src_b} !== {4'd7, 2'b10, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL rtype_exec got %b exp %b", {bus.state, bus.aluop, bus.alu_src_a, bus.alu_src_b}, {4'd7, 2'b10, 1'b1, 2'b00});
        end
        step;
        checks++;
        if ({bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== {4'd8, 3'b110}) begin
            errors++;
            $display("FAIL rtype_aluwb got %b exp %b", {bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg}, {4'd8, 3'b110});
        end
        step;
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL rtype_back_to_fetch got %0d exp 1", bus.state);
        end
    endtask

    task automatic test_lw_stall;
        bus.opcode = OP_LW;
        step;
        step;
        checks++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop} !== {4'd3, 1'b1, 2'b10, 2'b00}) begin
            errors++;
            $display("FAIL lw_memadr got %b exp %b", {bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop}, {4'd3, 1'b1, 2'b10, 2'b00});
        end
        bus.mem_ready = 1'b0;
        step;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.state, bus.mem_read, bus.i_or_d} !== {4'd4, 2'b11}) begin
                errors++;
                $display("FAIL lw_memrd_cycle%0d got %b exp %b", i, {bus.state, bus.mem_read, bus.i_or_d}, {4'd4, 2'b11});
            end
            if (i == 3) bus.mem_ready = 1'b1;
            else step;
        end
        step;
        checks++;
        if ({bus.state, bus.reg_write, bus.mem_to_reg, bus.mem_timeout} !== {4'd5, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL lw_memwb got %b exp %b", {bus.state, bus.reg_write, bus.mem_to_reg, bus.mem_timeout}, {4'd5, 2'b11, 1'b0});
        end
        step;
    endtask

    task automatic test_sw;
        bus.opcode = OP_SW;
        step;
        step;
        // opcode changed after DECODE must not redirect the access
        bus.opcode = OP_LW;
        step;
        checks++;
        if ({bus.state, bus.mem_write, bus.i_or_d, bus.reg_write} !== {4'd6, 3'b110}) begin
            errors++;
            $display("FAIL sw_memwr got %b exp %b", {bus.state, bus.mem_write, bus.i_or_d, bus.reg_write}, {4'd6, 3'b110});
        end
        bus.mem_ready = 1'b0;
        step;
        checks++;
        if ({bus.state, bus.mem_write, bus.reg_write} !== {4'd6, 2'b10}) begin
            errors++;
            $display("FAIL sw_memwr_stall got %b exp %b", {bus.state, bus.mem_write, bus.reg_write}, {4'd6, 2'b10});
        end
        bus.mem_ready = 1'b1;
        step;
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL sw_back_to_fetch got %0d exp 1", bus.state);
        end
    endtask

    task automatic test_branch_jump;
        bus.opcode = OP_BEQ;
        step;
        step;
        checks++;
        if ({bus.state, bus.aluop, bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.pc_write} !== {4'd9, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL beq_branch got %b exp %b",
                     {bus.state, bus.aluop, bus.pc_write_cond, bus.pc_source, bus.alu_src_a, bus.pc_write},
                     {4'd9, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0});
        end
        step;
        bus.opcode = OP_J;
        step;
        step;
        checks++;
        if ({bus.state, bus.pc_source, bus.pc_write, bus.pc_write_cond} !== {4'd10, 2'b10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL j_jump got %b exp %b", {bus.state, bus.pc_source, bus.pc_write, bus.pc_write_cond}, {4'd10, 2'b10, 1'b1, 1'b0});
        end
        step;
    endtask

    task automatic test_illegal;
        bus.opcode = 6'b111111;
        step;
        checks++;
        if ({bus.state, bus.illegal_op} !== {4'd2, 1'b1}) begin
            errors++;
            $display("FAIL illegal_pulse got %b exp %b", {bus.state, bus.illegal_op}, {4'd2, 1'b1});
        end
        step;
        checks++;
        if ({bus.state, bus.illegal_op} !== {4'd1, 1'b0}) begin
            errors++;
            $display("FAIL illegal_after got %b exp %b", {bus.state, bus.illegal_op}, {4'd1, 1'b0});
        end
    endtask

    task automatic test_timeout_and_reset;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if ({bus.mem_read, bus.ir_write, bus.pc_write} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_stall_gating got %b exp 100", {bus.mem_read, bus.ir_write, bus.pc_write});
        end
        for (int k = 1; k <= 20; k++) begin
            step;
            if (k == 14) begin
                checks++;
                if (bus.mem_timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_early got %b exp 0", bus.mem_timeout);
                end
            end
            if (k == 15 || k == 20) begin
                checks++;
                if ({bus.state, bus.mem_timeout} !== {4'd1, 1'b1}) begin
                    errors++;
                    $display("FAIL timeout_k%0d got %b exp %b", k, {bus.state, bus.mem_timeout}, {4'd1, 1'b1});
                end
            end
        end
        bus.mem_ready = 1'b1;
        bus.opcode = OP_LW;
        step;
        step;
        bus.mem_ready = 1'b0;
        step;
        checks++;
        if ({bus.state, bus.mem_read, bus.mem_timeout} !== {4'd4, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL timeout_sticky_memrd got %b exp %b", {bus.state, bus.mem_read, bus.mem_timeout}, {4'd4, 1'b1, 1'b1});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.state, all_out, bus.mem_timeout} !== 22'd0) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", {bus.state, all_out, bus.mem_timeout}, 22'd0);
        end
        step;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        step;
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL restart_fetch got %0d exp 1", bus.state);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_rtype;
        test_lw_stall;
        test_sw;
        test_branch_jump;
        test_illegal;
        test_timeout_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
